// File: rtl/pcs_rx_link_ctrl.sv
// PCS receive link controller: sequences transceiver bring-up, PCS rx reset,
// block-lock acquisition and 802.3-style hi-BER monitoring on the rx clock.
module pcs_rx_link_ctrl #(
   parameter int RESET_CYCLES = 16,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int BER_WINDOW   = 19531,
   parameter int BER_THRESH   = 16,
   parameter int HIBER_LIMIT  = 8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_xver_rx_ready,
   input  logic        i_block_lock,
   input  logic [1:0]  i_header,
   input  logic        i_valid,
   input  logic        i_clear_count,
   output logic        o_pcs_reset,
   output logic        o_link_up,
   output logic        o_hi_ber,
   output logic [15:0] o_err_count,
   output logic [2:0]  o_state
);

   typedef enum logic [2:0] {
      WAIT_XVER  = 3'd0,
      RESET_HOLD = 3'd1,
      WAIT_LOCK  = 3'd2,
      LINK_UP    = 3'd3,
      HI_BER     = 3'd4
   } state_t;

   // One shared timer serves both RESET_HOLD and WAIT_LOCK, so size it for the longer.
   localparam int TMAX = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int WW   = $clog2(BER_WINDOW + 1);
   localparam int BW   = $clog2(BER_THRESH + 1);
   localparam int HW   = $clog2(HIBER_LIMIT + 1);

   localparam logic [TW-1:0] RESET_LAST = TW'(RESET_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [WW-1:0] WIN_LAST   = WW'(BER_WINDOW - 1);
   localparam logic [BW-1:0] BAD_MAX    = BW'(BER_THRESH);
   localparam logic [HW-1:0] HIB_MAX    = HW'(HIBER_LIMIT);

   state_t          state, state_n;
   logic [TW-1:0]   timer, timer_n;
   logic [WW-1:0]   win_cnt, win_cnt_n;
   logic [BW-1:0]   bad_cnt, bad_cnt_n, bad_inc;
   logic [HW-1:0]   hib_cnt, hib_cnt_n, hib_inc;
   logic            invalid;
   logic            win_wrap;

   assign invalid  = i_valid && ((i_header == 2'b00) || (i_header == 2'b11));
   assign win_wrap = (win_cnt == WIN_LAST);
   // Window error count including this cycle's header, saturating at the threshold.
   assign bad_inc  = (invalid && (bad_cnt != BAD_MAX)) ? bad_cnt + BW'(1) : bad_cnt;
   assign hib_inc  = hib_cnt + HW'(1);
   assign o_state  = state;

   // Next-state and next-counter logic.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_n   = state;
      timer_n   = timer + TW'(1);
      win_cnt_n = win_wrap ? '0 : win_cnt + WW'(1);
      bad_cnt_n = win_wrap ? '0 : bad_inc;
      hib_cnt_n = hib_cnt;

      case (state)
         WAIT_XVER: begin
            timer_n = '0;
            if (i_xver_rx_ready) state_n = RESET_HOLD;
         end
         RESET_HOLD: begin
            if (timer == RESET_LAST) begin
               state_n = WAIT_LOCK;
               timer_n = '0;
            end
         end
         WAIT_LOCK: begin
            if (i_block_lock) begin
               state_n   = LINK_UP;
               win_cnt_n = '0;
               bad_cnt_n = '0;
            end else if (timer == LOCK_LAST) begin
               state_n = RESET_HOLD;
               timer_n = '0;
            end
         end
         LINK_UP: begin
            timer_n = '0;
            if (!i_block_lock) begin
               state_n = WAIT_LOCK;
            end else if (bad_inc == BAD_MAX) begin
               state_n   = HI_BER;
               win_cnt_n = '0;
               bad_cnt_n = '0;
               hib_cnt_n = '0;
            end
         end
         HI_BER: begin
            timer_n = '0;
            if (!i_block_lock) begin
               state_n = WAIT_LOCK;
            end else if (win_wrap) begin
               if (bad_inc != BAD_MAX) begin
                  state_n = LINK_UP;
               end else if (hib_inc == HIB_MAX) begin
                  state_n = RESET_HOLD;
               end else begin
                  hib_cnt_n = hib_inc;
               end
            end
         end
         default: begin
            state_n = WAIT_XVER;
            timer_n = '0;
         end
      endcase

      // Losing the transceiver overrides everything else.
      if (!i_xver_rx_ready) begin
         state_n = WAIT_XVER;
         timer_n = '0;
      end
   end

   // State, timers and registered status outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= WAIT_XVER;
         timer       <= '0;
         win_cnt     <= '0;
         bad_cnt     <= '0;
         hib_cnt     <= '0;
         o_pcs_reset <= 1'b1;
         o_link_up   <= 1'b0;
         o_hi_ber    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state       <= state_n;
         timer       <= timer_n;
         win_cnt     <= win_cnt_n;
         bad_cnt     <= bad_cnt_n;
         hib_cnt     <= hib_cnt_n;
         o_pcs_reset <= (state_n == WAIT_XVER) || (state_n == RESET_HOLD);
         o_link_up   <= (state_n == LINK_UP);
         o_hi_ber    <= (state_n == HI_BER);
      end
   end

   // Saturating invalid-header counter; a clear beats a coincident increment.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_err_count <= '0;
      end else if (i_clear_count) begin
         o_err_count <= '0;
      end else if (invalid && ((state == LINK_UP) || (state == HI_BER)) &&
                   (o_err_count != 16'hFFFF)) begin
         o_err_count <= o_err_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_pcs_rx_link_ctrl.sv
// Directed bench for pcs_rx_link_ctrl with shortened timeout/window parameters.
module tb_pcs_rx_link_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic        lock;
   logic [1:0]  hdr;
   logic        valid;
   logic        clr;
   logic        pcs_reset;
   logic        link_up;
   logic        hi_ber;
   logic [15:0] err_count;
   logic [2:0]  state;

   int checks = 0;
   int errors = 0;

   pcs_rx_link_ctrl #(
      .RESET_CYCLES(16),
      .LOCK_TIMEOUT(100),
      .BER_WINDOW  (200),
      .BER_THRESH  (16),
      .HIBER_LIMIT (2)
   ) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_xver_rx_ready(ready),
      .i_block_lock   (lock),
      .i_header       (hdr),
      .i_valid        (valid),
      .i_clear_count  (clr),
      .o_pcs_reset    (pcs_reset),
      .o_link_up      (link_up),
      .o_hi_ber       (hi_ber),
      .o_err_count    (err_count),
      .o_state        (state)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic test_reset();
      rst = 1'b1; ready = 1'b0; lock = 1'b0; hdr = 2'b01; valid = 1'b0; clr = 1'b0;
      #2;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
      checks++; if (pcs_reset !== 1'b1) begin errors++; $display("FAIL reset_pcs got %b exp 1", pcs_reset); end
      checks++; if (link_up !== 1'b0 || hi_ber !== 1'b0) begin errors++; $display("FAIL reset_flags got link=%b hiber=%b exp 0 0", link_up, hi_ber); end
      checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err got %0h exp 0", err_count); end
      steps(2);
      rst = 1'b0;
      step();
      checks++; if (state !== 3'd0 || pcs_reset !== 1'b1) begin errors++; $display("FAIL idle_no_ready got state=%0d pcs=%b exp 0 1", state, pcs_reset); end
   endtask

   task automatic test_bringup();
      int n;
      steps(3);
      ready = 1'b1;
      n = 0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (pcs_reset === 1'b1) n++;
         else break;
      end
      checks++; if (n != 16) begin errors++; $display("FAIL reset_hold_len got %0d exp 16", n); end
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL enter_wait_lock got %0d exp 2", state); end
      steps(17);
      checks++; if (state !== 3'd2 || link_up !== 1'b0) begin errors++; $display("FAIL waiting_lock got state=%0d link=%b exp 2 0", state, link_up); end
      lock = 1'b1;
      step();
      checks++; if (state !== 3'd3 || link_up !== 1'b1 || pcs_reset !== 1'b0) begin
         errors++; $display("FAIL link_up got state=%0d link=%b pcs=%b exp 3 1 0", state, link_up, pcs_reset);
      end
   endtask

   task automatic test_lock_timeout();
      logic exp_pcs;
      lock = 1'b0;
      step();
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL lock_loss got %0d exp 2", state); end
      for (int k = 1; k <= 232; k++) begin
         step();
         exp_pcs = ((k % 116) >= 100);
         checks++;
         if (pcs_reset !== exp_pcs || link_up !== 1'b0) begin
            errors++; $display("FAIL timeout_k%0d got pcs=%b link=%b exp %b 0", k, pcs_reset, link_up, exp_pcs);
         end
      end
      lock = 1'b1;
      step();
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL relock got %0d exp 3", state); end
   endtask

   task automatic test_hi_ber();
      hdr = 2'b11; valid = 1'b0;
      steps(10);
      valid = 1'b1;
      steps(15);
      checks++; if (state !== 3'd3 || link_up !== 1'b1) begin errors++; $display("FAIL below_thresh got state=%0d link=%b exp 3 1", state, link_up); end
      step();
      checks++; if (state !== 3'd4 || hi_ber !== 1'b1 || link_up !== 1'b0) begin
         errors++; $display("FAIL hi_ber_declare got state=%0d hiber=%b link=%b exp 4 1 0", state, hi_ber, link_up);
      end
      for (int i = 0; i < 199; i++) begin
         hdr = (i < 3) ? 2'b11 : 2'b01;
         step();
      end
      checks++; if (state !== 3'd4) begin errors++; $display("FAIL hi_ber_hold got %0d exp 4", state); end
      hdr = 2'b01;
      step();
      checks++; if (state !== 3'd3 || hi_ber !== 1'b0 || link_up !== 1'b1) begin
         errors++; $display("FAIL hi_ber_clear got state=%0d hiber=%b link=%b exp 3 0 1", state, hi_ber, link_up);
      end
      checks++; if (err_count !== 16'd19) begin errors++; $display("FAIL err_count_19 got %0d exp 19", err_count); end
   endtask

   task automatic test_persistence();
      int bad;
      bad = 0;
      valid = 1'b1;
      for (int n = 0; n < 216; n++) begin
         hdr = (n >= 185) ? 2'b00 : 2'b01;
         step();
         if (n < 215 && state !== 3'd3) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL fifteen_per_window got %0d bad cycles exp 0", bad); end
      checks++; if (state !== 3'd4) begin errors++; $display("FAIL straddle_16th got %0d exp 4", state); end
      steps(399);
      checks++; if (state !== 3'd4 || hi_ber !== 1'b1) begin errors++; $display("FAIL hiber_window1 got state=%0d hiber=%b exp 4 1", state, hi_ber); end
      step();
      checks++; if (state !== 3'd1 || pcs_reset !== 1'b1 || hi_ber !== 1'b0) begin
         errors++; $display("FAIL hiber_limit got state=%0d pcs=%b hiber=%b exp 1 1 0", state, pcs_reset, hi_ber);
      end
      checks++; if (err_count !== 16'd450) begin errors++; $display("FAIL err_count_450 got %0d exp 450", err_count); end
      valid = 1'b0;
      steps(16);
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL rehold_len got %0d exp 2", state); end
      step();
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL relink got %0d exp 3", state); end
   endtask

   task automatic test_priority();
      ready = 1'b0; lock = 1'b0;
      step();
      checks++; if (state !== 3'd0 || pcs_reset !== 1'b1 || link_up !== 1'b0) begin
         errors++; $display("FAIL xver_priority got state=%0d pcs=%b link=%b exp 0 1 0", state, pcs_reset, link_up);
      end
      ready = 1'b1; lock = 1'b1;
      step();
      steps(17);
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL bringup_again got %0d exp 3", state); end
      hdr = 2'b11; valid = 1'b1;
      steps(15);
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL pre_16th got %0d exp 3", state); end
      lock = 1'b0;
      step();
      checks++; if (state !== 3'd2 || hi_ber !== 1'b0 || link_up !== 1'b0) begin
         errors++; $display("FAIL lock_beats_ber got state=%0d hiber=%b link=%b exp 2 0 0", state, hi_ber, link_up);
      end
      valid = 1'b0;
      checks++; if (err_count !== 16'd466) begin errors++; $display("FAIL err_count_466 got %0d exp 466", err_count); end
   endtask

   task automatic test_counter();
      bit hit;
      lock = 1'b1;
      step();
      clr = 1'b1; hdr = 2'b00; valid = 1'b1;
      step();
      clr = 1'b0;
      checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clear_wins got %0h exp 0", err_count); end
      hit = 1'b0;
      for (int i = 0; i < 80000; i++) begin
         step();
         if (err_count === 16'hFFFF) begin hit = 1'b1; break; end
      end
      checks++; if (!hit) begin errors++; $display("FAIL reach_ffff got %0h exp ffff", err_count); end
      valid = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (state === 3'd3) begin hit = 1'b1; break; end
         step();
      end
      checks++; if (!hit) begin errors++; $display("FAIL back_to_link got %0d exp 3", state); end
      hdr = 2'b11; valid = 1'b1;
      step();
      valid = 1'b0;
      checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL saturate got %0h exp ffff", err_count); end
   endtask

   task automatic test_async_reset();
      #3;
      rst = 1'b1;
      #1;
      checks++; if (state !== 3'd0 || pcs_reset !== 1'b1 || link_up !== 1'b0 || hi_ber !== 1'b0 || err_count !== 16'd0) begin
         errors++; $display("FAIL async_reset got state=%0d pcs=%b link=%b hiber=%b err=%0h exp 0 1 0 0 0",
                            state, pcs_reset, link_up, hi_ber, err_count);
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_lock_timeout();
      test_hi_ber();
      test_persistence();
      test_priority();
      test_counter();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
